// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte image, writes its payload to program memory,
// and holds the CPU in reset until a frame arrives with a valid checksum.
module prog_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 1000,
    parameter int          ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_H, S_LEN_L, S_ADDR_H, S_ADDR_L, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t            r_state, w_next;
    logic [15:0]       r_len;
    logic [7:0]        r_addr_h, r_sum, r_wdata;
    logic [ADDR_W-1:0] r_ptr, r_addr;
    logic [TW-1:0]     r_tmo;
    logic              r_we, r_cpu_rst, r_done, r_err;
    logic              w_acc, w_busy, w_tmo;

    assign in_ready  = 1'b1;
    assign w_acc     = in_valid;
    assign w_busy    = r_state inside {S_LEN_H, S_LEN_L, S_ADDR_H, S_ADDR_L, S_DATA, S_CSUM};
    // Expiry takes priority over a byte arriving in the same cycle.
    assign w_tmo     = w_busy && (r_tmo == TW'(TIMEOUT));
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_rst   = r_cpu_rst;
    assign busy      = w_busy;
    assign done      = r_done;
    assign err       = r_err;

    always_comb begin
        w_next = r_state;
        if (w_tmo)
            w_next = S_ERROR;
        else if (w_acc)
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: w_next = (in_data == SYNC_BYTE) ? S_LEN_H : r_state;
                S_LEN_H:  w_next = S_LEN_L;
                S_LEN_L:  w_next = S_ADDR_H;
                S_ADDR_H: w_next = S_ADDR_L;
                S_ADDR_L: w_next = (r_len == 16'd0) ? S_CSUM : S_DATA;
                S_DATA:   w_next = (r_len == 16'd1) ? S_CSUM : S_DATA;
                S_CSUM:   w_next = (in_data == r_sum) ? S_DONE : S_ERROR;
                default:  w_next = S_IDLE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_addr_h  <= '0;
            r_sum     <= '0;
            r_ptr     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_tmo     <= '0;
            r_we      <= 1'b0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_we    <= 1'b0;
            r_tmo   <= (w_busy && !w_acc && !w_tmo) ? r_tmo + TW'(1) : '0;
            if (w_acc && !w_tmo)
                case (r_state)
                    S_LEN_H:  r_len[15:8] <= in_data;
                    S_LEN_L:  r_len[7:0]  <= in_data;
                    S_ADDR_H: r_addr_h    <= in_data;
                    S_ADDR_L: r_ptr       <= ADDR_W'({r_addr_h, in_data});
                    S_DATA: begin
                        r_we    <= 1'b1;
                        r_addr  <= r_ptr;
                        r_wdata <= in_data;
                        r_ptr   <= r_ptr + ADDR_W'(1);
                        r_sum   <= r_sum + in_data;
                        r_len   <= r_len - 16'd1;
                    end
                    default: ;
                endcase
            if (w_next != r_state) begin
                if (w_next == S_LEN_H) begin
                    r_cpu_rst <= 1'b1;
                    r_done    <= 1'b0;
                    r_err     <= 1'b0;
                    r_sum     <= '0;
                end
                if (w_next == S_DONE) begin
                    r_cpu_rst <= 1'b0;
                    r_done    <= 1'b1;
                end
                if (w_next == S_ERROR) begin
                    r_cpu_rst <= 1'b1;
                    r_err     <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: drives framed images into prog_loader and checks memory writes
// against a queue of expected (address, data) pairs plus status flags per scenario.
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, cpu_rst, busy, done, err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  pay[$];

    prog_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(16), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Every strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (mem_we) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write got addr=%h data=%h want no write", mem_addr, mem_wdata);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                             mem_addr, mem_wdata, e[23:8], e[7:0]);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic frame(input logic [15:0] a, input logic [7:0] cs);
        logic [15:0] len;
        logic [15:0] p;
        len = 16'(pay.size());
        p   = a;
        send(8'hA5);
        send(len[15:8]);
        send(len[7:0]);
        send(a[15:8]);
        send(a[7:0]);
        foreach (pay[i]) begin
            exp_q.push_back({p, pay[i]});
            p = p + 16'd1;
            send(pay[i]);
        end
        send(cs);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset got rdy=%b we=%b addr=%h wd=%h crst=%b busy=%b done=%b err=%b want 1 0 0000 00 1 0 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good;
        pay = '{8'h11, 8'h22, 8'h33};
        frame(16'h0100, 8'h66);
        n_vec++;
        if ({done, err, cpu_rst, busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL good_status got done/err/crst/busy=%b want 1000", {done, err, cpu_rst, busy});
        end
    endtask

    task automatic test_bad_csum;
        pay = '{8'h11, 8'h22, 8'h33};
        frame(16'h0100, 8'h67);
        n_vec++;
        if ({done, err, cpu_rst, busy} !== 4'b0110) begin
            n_err++;
            $display("FAIL bad_csum got done/err/crst/busy=%b want 0110", {done, err, cpu_rst, busy});
        end
    endtask

    task automatic test_wrap;
        pay = '{8'hAA, 8'hBB};
        frame(16'hFFFF, 8'h65);
        n_vec++;
        if ({done, err, cpu_rst, busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL wrap_status got done/err/crst/busy=%b want 1000", {done, err, cpu_rst, busy});
        end
    endtask

    task automatic test_zero_len;
        pay = {};
        frame(16'h1234, 8'h00);
        n_vec++;
        if ({done, err, cpu_rst, busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL zero_len_good got done/err/crst/busy=%b want 1000", {done, err, cpu_rst, busy});
        end
        frame(16'h1234, 8'h01);
        n_vec++;
        if ({done, err, cpu_rst, busy} !== 4'b0110) begin
            n_err++;
            $display("FAIL zero_len_bad got done/err/crst/busy=%b want 0110", {done, err, cpu_rst, busy});
        end
    endtask

    task automatic test_timeout;
        int k;
        send(8'hA5);
        n_vec++;
        if ({done, err, cpu_rst, busy} !== 4'b0011) begin
            n_err++;
            $display("FAIL frame_start got done/err/crst/busy=%b want 0011", {done, err, cpu_rst, busy});
        end
        send(8'h00);
        send(8'h05);
        k = 0;
        while (!err && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (k < 16 || k > 18 || {done, err, cpu_rst, busy} !== 4'b0110) begin
            n_err++;
            $display("FAIL timeout got idle=%0d done/err/crst/busy=%b want idle 16..18 and 0110", k, {done, err, cpu_rst, busy});
        end
        pay = '{8'h01, 8'h02};
        frame(16'h0200, 8'h03);
        n_vec++;
        if ({done, err, cpu_rst, busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL after_timeout got done/err/crst/busy=%b want 1000", {done, err, cpu_rst, busy});
        end
    endtask

    task automatic test_back_to_back;
        pay = '{8'hA5, 8'h01};
        frame(16'h0300, 8'hA6);
        pay = '{8'h10, 8'h20, 8'h30, 8'h40};
        frame(16'h0400, 8'hA0);
        n_vec++;
        if ({done, err, cpu_rst, busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL back_to_back got done/err/crst/busy=%b want 1000", {done, err, cpu_rst, busy});
        end
    endtask

    task automatic test_garbage_and_rst;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        n_vec++;
        if ({done, err, cpu_rst, busy} !== 4'b0010) begin
            n_err++;
            $display("FAIL garbage got done/err/crst/busy=%b want 0010", {done, err, cpu_rst, busy});
        end
        pay = '{8'h11, 8'h22, 8'h33};
        frame(16'h0100, 8'h66);
        n_vec++;
        if ({done, err, cpu_rst, busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL garbage_then_good got done/err/crst/busy=%b want 1000", {done, err, cpu_rst, busy});
        end
        send(8'hA5);
        send(8'h00);
        send(8'h04);
        send(8'h02);
        send(8'h00);
        exp_q.push_back({16'h0200, 8'h01});
        send(8'h01);
        exp_q.push_back({16'h0201, 8'h02});
        send(8'h02);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h03);
        send(8'h04);
        send(8'h05);
        n_vec++;
        if ({done, err, cpu_rst, busy} !== 4'b0010) begin
            n_err++;
            $display("FAIL mid_frame_rst got done/err/crst/busy=%b want 0010", {done, err, cpu_rst, busy});
        end
    endtask

    initial begin
        test_reset;
        test_good;
        test_bad_csum;
        test_wrap;
        test_zero_len;
        test_timeout;
        test_back_to_back;
        test_garbage_and_rst;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_writes got %0d outstanding want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader: the writer side of the CPU's 64 KiB byte program memory.
- Accepts a framed image from a byte source (UART RX or testbench) and writes the payload into memory through a write port.
- Holds the CPU in reset until a frame passes its checksum, then releases it.
- Sits between the serial receiver and the CPU's instruction/data memory.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1000, maximum idle clocks between bytes inside a frame before abort.
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  incoming byte.
- in_valid  in  1  in_data valid this cycle.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  memory write strobe, one cycle per byte.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- cpu_rst  out  1  reset to CPU, active-high.
- busy  out  1  frame in progress.
- done  out  1  last frame loaded with good checksum.
- err  out  1  last frame failed (checksum or timeout).

Behaviour:
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0, done=0, err=0; state=IDLE; internal counters cleared.
- Reset mid-frame aborts the frame. Memory already written is not rolled back.
- Byte transfer occurs when in_valid && in_ready. in_ready is constantly 1; the loader never stalls.
- Frame format, in order:
  - SYNC_BYTE
  - LEN_H, LEN_L: payload byte count N, 0..65535
  - ADDR_H, ADDR_L: start address A
  - N payload bytes
  - CSUM: 8-bit modulo-256 sum of the payload bytes only
- State machine, one transition per accepted byte:
  - IDLE: byte==SYNC_BYTE -> LEN_H. Other bytes are ignored.
  - LEN_H -> LEN_L -> ADDR_H -> ADDR_L.
  - ADDR_L: -> DATA if N!=0, else -> CSUM.
  - DATA: each byte is written; -> CSUM after the Nth byte.
  - CSUM: byte==running sum -> DONE, else -> ERROR.
  - DONE / ERROR: byte==SYNC_BYTE -> LEN_H, starting a new frame. Other bytes are ignored.
- Writes:
  - In DATA, an accepted byte produces mem_we=1 on the next cycle, with mem_addr = current pointer and mem_wdata = byte.
  - The pointer starts at A and increments by 1 per byte, wrapping 16'hFFFF -> 16'h0000.
  - mem_we is exactly 1 cycle wide. Back-to-back bytes produce back-to-back strobes.
- Checksum:
  - 8-bit accumulator, cleared on entering LEN_H.
  - Adds each payload byte, discarding carry.
- Status outputs:
  - busy=1 in LEN_H through CSUM.
  - Entering LEN_H: cpu_rst=1, done=0, err=0.
  - Entering DONE: cpu_rst=0 and done=1, both registered, asserted the cycle after the CSUM byte is accepted.
  - Entering ERROR: err=1 and cpu_rst stays 1.
  - done and err are sticky until the next SYNC_BYTE in DONE/ERROR, or rst.
- Timeout:
  - In LEN_H..CSUM, a counter increments on every cycle without an accepted byte and clears on each accepted byte.
  - When the counter reaches TIMEOUT -> ERROR (err=1, busy=0).
  - The counter is inactive in IDLE/DONE/ERROR.
- Inside a frame, a SYNC_BYTE value is treated as ordinary data; there is no resync.
- A byte accepted in the same cycle as the timeout expiry is discarded, and the timeout wins.

Test Plan:
- Frame A5 00 03 01 00 11 22 33 66, bytes back-to-back → writes (0x0100,0x11), (0x0101,0x22), (0x0102,0x33) on consecutive cycles; done=1, cpu_rst=0 one cycle after 0x66; err=0.
- Same frame with CSUM=0x67 → three writes still occur; err=1, done=0, cpu_rst=1.
- A5 00 02 FF FF AA BB 65 → writes (0xFFFF,0xAA) then (0x0000,0xBB); done=1.
- A5 00 00 12 34 00 → no mem_we; done=1. The same with CSUM=0x01 → err=1.
- TIMEOUT=16; A5 00 05 then 16 idle cycles → err=1, busy=0, cpu_rst=1. A following good frame → done=1, err=0.
- Garbage 00 FF 5A before a good frame → ignored, no writes. rst asserted after the 2nd payload byte → state IDLE, cpu_rst=1, no further writes.
